// File: rtl/gecko_writeback_arbiter.sv
// Rotating round-robin writeback scheduler for the gecko pipeline.
// A per-register status table keeps results for one destination in tag order.
module gecko_writeback_arbiter #(
    parameter  int NUM_INPUTS   = 3,
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDR_WIDTH   = 5,
    parameter  int STATUS_WIDTH = 2,
    localparam int SRC_WIDTH    = $clog2(NUM_INPUTS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    output logic [NUM_INPUTS-1:0]              in_ready,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   in_addr,
    input  logic [NUM_INPUTS*STATUS_WIDTH-1:0] in_status,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ADDR_WIDTH-1:0]              out_addr,
    output logic [STATUS_WIDTH-1:0]            out_status,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [SRC_WIDTH-1:0]               out_source,
    output logic                               init_done
);

    localparam int                 DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [SRC_WIDTH:0] NUM_W = (SRC_WIDTH + 1)'(NUM_INPUTS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [STATUS_WIDTH-1:0] table_r [DEPTH];
    logic [ADDR_WIDTH-1:0]   clear_cnt_r;
    logic [SRC_WIDTH-1:0]    rr_ptr_r;
    logic [NUM_INPUTS-1:0]   elig_s;
    logic [SRC_WIDTH-1:0]    cand_s;
    logic [SRC_WIDTH-1:0]    grant_idx_s;
    logic                    grant_s;
    logic                    adv_s;
    logic                    run_s;
    logic [ADDR_WIDTH-1:0]   g_addr_s;
    logic [STATUS_WIDTH-1:0] g_status_s;
    logic [DATA_WIDTH-1:0]   g_data_s;

    // Channel index base+offs modulo NUM_INPUTS; both operands stay below NUM_INPUTS.
    function automatic logic [SRC_WIDTH-1:0] rot_idx(input logic [SRC_WIDTH-1:0] base,
                                                     input logic [SRC_WIDTH:0]   offs);
        logic [SRC_WIDTH:0] sum;
        sum = {1'b0, base} + offs;
        sum = (sum >= NUM_W) ? (sum - NUM_W) : sum;
        return sum[SRC_WIDTH-1:0];
    endfunction

    assign run_s = (state_r == ST_RUN);
    assign adv_s = !out_valid || out_ready;

    // Eligibility, rotating search (highest offset first so the nearest hit wins) and grant mux.
    always_comb begin
        elig_s      = '0;
        cand_s      = '0;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        g_addr_s    = '0;
        g_status_s  = '0;
        g_data_s    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            elig_s[i] = in_valid[i] &&
                (table_r[in_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] == in_status[i*STATUS_WIDTH +: STATUS_WIDTH]);
        end
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand_s      = rot_idx(rr_ptr_r, (SRC_WIDTH + 1)'(k));
            grant_idx_s = elig_s[cand_s] ? cand_s : grant_idx_s;
            grant_s     = grant_s | elig_s[cand_s];
        end
        grant_s = grant_s & run_s & adv_s;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            g_addr_s   = (grant_idx_s == SRC_WIDTH'(i)) ? in_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : g_addr_s;
            g_status_s = (grant_idx_s == SRC_WIDTH'(i)) ? in_status[i*STATUS_WIDTH +: STATUS_WIDTH] : g_status_s;
            g_data_s   = (grant_idx_s == SRC_WIDTH'(i)) ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : g_data_s;
        end
    end

    // One-hot ready for the granted channel only; combinational on out_ready by design.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = grant_s && (grant_idx_s == SRC_WIDTH'(i));
        end
    end

    // INIT leaves after the last table entry has been cleared.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: state_nxt_s = (clear_cnt_r == '1) ? ST_RUN : ST_INIT;
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State, clear counter (wraps back to zero on the last entry) and init flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_INIT;
            clear_cnt_r <= '0;
            init_done   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                clear_cnt_r <= clear_cnt_r + ADDR_WIDTH'(1);
                init_done   <= (clear_cnt_r == '1);
            end
        end
    end

    // Status table: cleared entry by entry in INIT, advanced by one tag on each grant.
    always_ff @(posedge clk) begin
        if (!run_s) begin
            table_r[clear_cnt_r] <= '0;
        end else if (grant_s) begin
            table_r[g_addr_s] <= g_status_s + STATUS_WIDTH'(1);
        end
    end

    // Output slot and round-robin pointer; the slot holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_status <= '0;
            out_data   <= '0;
            out_source <= '0;
            rr_ptr_r   <= '0;
        end else if (run_s && adv_s) begin
            if (grant_s) begin
                out_valid  <= 1'b1;
                out_addr   <= g_addr_s;
                out_status <= g_status_s;
                out_data   <= g_data_s;
                out_source <= grant_idx_s;
                rr_ptr_r   <= rot_idx(grant_idx_s, (SRC_WIDTH + 1)'(1));
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gecko_writeback_arbiter.sv
// Scoreboard bench for gecko_writeback_arbiter: a tag-table reference model predicts
// grants and pushes expected writebacks; a negedge monitor pops and compares them.
module tb_gecko_writeback_arbiter;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SW   = 2;
    localparam int SRCW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*AW-1:0]   in_addr;
    logic [N*SW-1:0]   in_status;
    logic [N*DW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_addr;
    logic [SW-1:0]     out_status;
    logic [DW-1:0]     out_data;
    logic [SRCW-1:0]   out_source;
    logic              init_done;

    gecko_writeback_arbiter #(
        .NUM_INPUTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STATUS_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_status(in_status), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_status(out_status), .out_data(out_data), .out_source(out_source),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [SW-1:0]   status;
        logic [DW-1:0]   data;
        logic [SRCW-1:0] src;
    } exp_t;

    exp_t          exp_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [SW-1:0] m_table [32];
    int            m_rr;
    int            init_left;
    logic [SW-1:0] alloc [32];
    bit            pend_v    [N];
    logic [AW-1:0] pend_addr [N];
    logic [SW-1:0] pend_tag  [N];
    logic [DW-1:0] pend_data [N];
    logic [N-1:0]  acc;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int ch, input logic [AW-1:0] addr, input logic [SW-1:0] tag);
        pend_v[ch]    = 1'b1;
        pend_addr[ch] = addr;
        pend_tag[ch]  = tag;
        pend_data[ch] = $urandom;
    endtask

    // Tags are handed out per destination in program order, as the pipeline would.
    task automatic issue_next(input int ch, input logic [AW-1:0] addr);
        issue(ch, addr, alloc[addr]);
        alloc[addr] = alloc[addr] + 2'd1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int a = 0; a < 32; a++) begin
            m_table[a] = '0;
            alloc[a]   = '0;
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        m_rr      = 0;
        init_left = 32;
        acc       = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]             = pend_v[i];
            in_addr[i*AW +: AW]     = pend_addr[i];
            in_status[i*SW +: SW]   = pend_tag[i];
            in_data[i*DW +: DW]     = pend_data[i];
        end
    endtask

    // Reference: one output slot; a result is taken when the slot frees and its tag is current.
    task automatic predict();
        logic [N-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        g = -1;
        if (init_left > 0) begin
            check(init_done == 1'b0, "init_done_low", init_done, 0);
            init_left--;
        end else begin
            check(init_done == 1'b1, "init_done_high", init_done, 1);
            if (exp_q.size() == 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (g < 0 && pend_v[c] && m_table[pend_addr[c]] == pend_tag[c]) g = c;
                end
            end
            if (g >= 0) begin
                exp_t e;
                exp_rdy[g] = 1'b1;
                e.addr   = pend_addr[g];
                e.status = pend_tag[g];
                e.data   = pend_data[g];
                e.src    = SRCW'(g);
                exp_q.push_back(e);
                m_table[pend_addr[g]] = pend_tag[g] + 2'd1;
                m_rr = (g + 1) % N;
            end
        end
        check(in_ready == exp_rdy, "in_ready", in_ready, exp_rdy);
        acc = in_valid & in_ready;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        #1;
        predict();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) pend_v[i] = 1'b0;
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0);
        for (int i = 0; i < N; i++) b = b | pend_v[i];
        return b;
    endfunction

    task automatic run_idle(input int maxc, input string name);
        int c;
        c = 0;
        while (busy() && c < maxc) begin
            cycle();
            c++;
        end
        check(c < maxc, name, c, maxc);
    endtask

    task automatic gen_rand();
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0) issue_next(i, AW'($urandom_range(0, 31)));
                else                           issue_next(i, AW'($urandom_range(4, 7)));
            end
        end
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor: the presented output must match the head of the scoreboard, held until taken.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check(out_valid == (exp_q.size() != 0), "out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                check({out_source, out_addr, out_status, out_data} == {e.src, e.addr, e.status, e.data},
                      "out_fields", {out_source, out_addr, out_status, out_data},
                      {e.src, e.addr, e.status, e.data});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int c;
        rst       = 1'b1;
        out_ready = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            pend_addr[i] = '0;
            pend_tag[i]  = '0;
            pend_data[i] = '0;
        end
        drive();
        #2;
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check({out_addr, out_status, out_data, out_source} == '0, "rst_out_fields",
              {out_addr, out_status, out_data, out_source}, 0);
        check(init_done == 1'b0, "rst_init_done", init_done, 0);
        check(in_ready == '0, "rst_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Results waiting through INIT, then granted 0,1,2 back to back.
        out_ready = 1'b1;
        issue_next(0, 5'd1);
        issue_next(1, 5'd2);
        issue_next(2, 5'd3);
        run_idle(60, "t2_drain");

        // Younger tag arrives first and must wait for the older one.
        issue(1, 5'd5, 2'd1);
        alloc[5] = 2'd2;
        repeat (4) cycle();
        check(pend_v[1] == 1'b1, "t3_stalled", pend_v[1], 1);
        issue(0, 5'd5, 2'd0);
        run_idle(20, "t3_drain");
        issue_next(2, 5'd5);
        run_idle(20, "t3_table_at_2");

        // Consumer stall of four cycles with all channels pending.
        issue_next(0, 5'd10);
        issue_next(1, 5'd11);
        issue_next(2, 5'd12);
        cycle();
        out_ready = 1'b0;
        repeat (4) cycle();
        out_ready = 1'b1;
        run_idle(20, "t4_drain");

        // Tag wrap on one register.
        issue_next(2, 5'd7);
        issue_next(1, 5'd7);
        issue_next(0, 5'd7);
        c = 0;
        while (pend_v[2] && c < 20) begin
            cycle();
            c++;
        end
        check(c < 20, "t5_first", c, 20);
        issue_next(2, 5'd7);
        run_idle(30, "t5_drain");
        issue_next(0, 5'd7);
        run_idle(20, "t5_wrapped_to_0");

        repeat (1500) begin
            gen_rand();
            cycle();
        end

        // Reset while an output is being presented.
        c = 0;
        while (!out_valid && c < 100) begin
            gen_rand();
            cycle();
            c++;
        end
        check(out_valid == 1'b1, "t6_setup", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "t6_async_clear", out_valid, 0);
        check(in_ready == '0, "t6_in_ready", in_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (500) begin
            gen_rand();
            cycle();
        end

        out_ready = 1'b1;
        run_idle(100, "final_drain");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
